// File: rtl/mux_scan_sequencer_pkg.sv
// Shared comparator-test definitions: scan FSM encoding and default mux geometry.
package mux_scan_sequencer_pkg;

    localparam int COMPTEST_NCH   = 16;
    localparam int COMPTEST_ADR_W = 4;
    localparam int COMPTEST_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_PULSE,
        ST_WAIT,
        ST_NEXT
    } scan_state_e;

endpackage

// File: rtl/mux_scan_sequencer_mux_adr_gen.sv
// Combinational target -> high/med/low mux address triple with a conflict flag.
module mux_adr_gen
    import mux_scan_sequencer_pkg::*;
#(
    parameter int NCH   = COMPTEST_NCH,
    parameter int ADR_W = COMPTEST_ADR_W
) (
    input  logic [ADR_W-1:0] target,
    output logic [ADR_W-1:0] high_adr,
    output logic [ADR_W-1:0] med_adr,
    output logic [ADR_W-1:0] low_adr,
    output logic             conflict
);

    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(NCH - 1);

    // Out-of-range targets and any coincident pair (always the case for NCH < 3) are conflicts.
    always_comb begin
        high_adr = target;
        med_adr  = (target == LAST_ADR) ? '0 : target + ADR_W'(1);
        low_adr  = (target == '0) ? LAST_ADR : target - ADR_W'(1);
        conflict = (32'(target) >= 32'(NCH)) ||
                   (high_adr == med_adr) ||
                   (high_adr == low_adr) ||
                   (med_adr == low_adr);
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Comparator-test pulse mux sequencer: per-channel settle, enable pulse, readout handshake.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int NCH   = COMPTEST_NCH,
    parameter int ADR_W = COMPTEST_ADR_W,
    parameter int CNT_W = COMPTEST_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             single_mode,
    input  logic [ADR_W-1:0] single_adr,
    input  logic [CNT_W-1:0] n_pulses,
    input  logic [CNT_W-1:0] settle_cyc,
    input  logic [CNT_W-1:0] pulse_cyc,
    input  logic             readout_ack,
    output logic [ADR_W-1:0] high_adr,
    output logic [ADR_W-1:0] med_adr,
    output logic [ADR_W-1:0] low_adr,
    output logic             mux_en_req,
    output logic             pulse_strobe,
    output logic             busy,
    output logic             done,
    output logic             conflict_err,
    output logic [CNT_W-1:0] cur_pulse
);

    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(NCH - 1);

    scan_state_e      state_q, state_d;
    logic [ADR_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_pulse_q, cur_pulse_d;
    logic [CNT_W-1:0] n_cfg_q, n_cfg_d;
    logic [CNT_W-1:0] settle_cfg_q, settle_cfg_d;
    logic [CNT_W-1:0] pulse_cfg_q, pulse_cfg_d;
    logic             single_q, single_d;
    logic             mux_en_q, mux_en_d;
    logic             strobe_q, strobe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [ADR_W-1:0] high_q, high_d;
    logic [ADR_W-1:0] med_q, med_d;
    logic [ADR_W-1:0] low_q, low_d;
    logic             adr_conflict_q, adr_conflict_d;
    logic [CNT_W:0]   next_pulse;
    logic [CNT_W-1:0] n_eff, settle_eff, pulse_eff;

    // Addresses are derived from the next target so they update together with SETTLE entry.
    mux_adr_gen #(
        .NCH   (NCH),
        .ADR_W (ADR_W)
    ) u_adr_gen (
        .target   (target_d),
        .high_adr (high_d),
        .med_adr  (med_d),
        .low_adr  (low_d),
        .conflict (adr_conflict_d)
    );

    assign n_eff      = (n_pulses == '0)   ? CNT_W'(1) : n_pulses;
    assign settle_eff = (settle_cyc == '0) ? CNT_W'(1) : settle_cyc;
    assign pulse_eff  = (pulse_cyc == '0)  ? CNT_W'(1) : pulse_cyc;

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        cnt_d        = cnt_q;
        cur_pulse_d  = cur_pulse_q;
        n_cfg_d      = n_cfg_q;
        settle_cfg_d = settle_cfg_q;
        pulse_cfg_d  = pulse_cfg_q;
        single_d     = single_q;
        mux_en_d     = 1'b0;
        strobe_d     = 1'b0;
        done_d       = 1'b0;
        err_d        = err_q;
        next_pulse   = {1'b0, cur_pulse_q} + (CNT_W+1)'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    single_d     = single_mode;
                    n_cfg_d      = n_eff;
                    settle_cfg_d = settle_eff;
                    pulse_cfg_d  = pulse_eff;
                    target_d     = single_mode ? single_adr : '0;
                    cur_pulse_d  = '0;
                    cnt_d        = settle_eff;
                    err_d        = 1'b0;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    if (adr_conflict_q) begin
                        err_d   = 1'b1;
                        state_d = ST_NEXT;
                    end else begin
                        mux_en_d = 1'b1;
                        strobe_d = 1'b1;
                        cnt_d    = pulse_cfg_q;
                        state_d  = ST_PULSE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_WAIT;
                end else begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    mux_en_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (readout_ack) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (next_pulse < {1'b0, n_cfg_q}) begin
                    cur_pulse_d = next_pulse[CNT_W-1:0];
                    cnt_d       = settle_cfg_q;
                    state_d     = ST_SETTLE;
                end else begin
                    cur_pulse_d = '0;
                    if (single_q || (target_q == LAST_ADR)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        target_d = target_q + ADR_W'(1);
                        cnt_d    = settle_cfg_q;
                        state_d  = ST_SETTLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over start and ack; the addresses are left where they were.
        if (abort) begin
            state_d     = ST_IDLE;
            target_d    = target_q;
            cnt_d       = '0;
            cur_pulse_d = '0;
            mux_en_d    = 1'b0;
            strobe_d    = 1'b0;
            done_d      = 1'b0;
            err_d       = err_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            target_q       <= '0;
            cnt_q          <= '0;
            cur_pulse_q    <= '0;
            n_cfg_q        <= '0;
            settle_cfg_q   <= '0;
            pulse_cfg_q    <= '0;
            single_q       <= 1'b0;
            mux_en_q       <= 1'b0;
            strobe_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            high_q         <= '0;
            med_q          <= '0;
            low_q          <= '0;
            adr_conflict_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            cnt_q          <= cnt_d;
            cur_pulse_q    <= cur_pulse_d;
            n_cfg_q        <= n_cfg_d;
            settle_cfg_q   <= settle_cfg_d;
            pulse_cfg_q    <= pulse_cfg_d;
            single_q       <= single_d;
            mux_en_q       <= mux_en_d;
            strobe_q       <= strobe_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            high_q         <= high_d;
            med_q          <= med_d;
            low_q          <= low_d;
            adr_conflict_q <= adr_conflict_d;
        end
    end

    assign high_adr     = high_q;
    assign med_adr      = med_q;
    assign low_adr      = low_q;
    assign mux_en_req   = mux_en_q;
    assign pulse_strobe = strobe_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign conflict_err = err_q;
    assign cur_pulse    = cur_pulse_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed scoreboard bench for mux_scan_sequencer (NCH=16 main instance, NCH=2 conflict instance).
module tb_mux_scan_sequencer;

    localparam int ACK_DLY = 2;

    typedef struct {
        logic [3:0] hi;
        logic [3:0] med;
        logic [3:0] lo;
        logic [7:0] cur;
        int         lo_run;
        int         hi_run;
    } exp_t;

    logic       clock;
    logic       reset_n;
    logic       start, start2, abort, single_mode;
    logic [3:0] single_adr;
    logic [7:0] n_pulses, settle_cyc, pulse_cyc;
    logic       readout_ack, ack_auto, ack_man, ack_en;

    logic [3:0] high_adr, med_adr, low_adr;
    logic       mux_en_req, pulse_strobe, busy, done, conflict_err;
    logic [7:0] cur_pulse;

    logic [3:0] high2, med2, low2;
    logic       en2, strobe2, busy2, done2, err2;
    logic [7:0] cur2;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur_exp;
    int   done_cnt = 0, strobe_cnt = 0;
    int   en2_cnt = 0, done2_cnt = 0, busy2_cyc = 0;
    int   lo_run = 0, hi_run = 0;
    logic prev_en = 1'b0;
    logic ack_prev = 1'b0;

    assign readout_ack = ack_auto | ack_man;

    mux_scan_sequencer #(.NCH(16), .ADR_W(4), .CNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .single_mode(single_mode), .single_adr(single_adr), .n_pulses(n_pulses),
        .settle_cyc(settle_cyc), .pulse_cyc(pulse_cyc), .readout_ack(readout_ack),
        .high_adr(high_adr), .med_adr(med_adr), .low_adr(low_adr),
        .mux_en_req(mux_en_req), .pulse_strobe(pulse_strobe), .busy(busy),
        .done(done), .conflict_err(conflict_err), .cur_pulse(cur_pulse)
    );

    mux_scan_sequencer #(.NCH(2), .ADR_W(4), .CNT_W(8)) dut2 (
        .clock(clock), .reset_n(reset_n), .start(start2), .abort(abort),
        .single_mode(single_mode), .single_adr(single_adr), .n_pulses(n_pulses),
        .settle_cyc(settle_cyc), .pulse_cyc(pulse_cyc), .readout_ack(readout_ack),
        .high_adr(high2), .med_adr(med2), .low_adr(low2),
        .mux_en_req(en2), .pulse_strobe(strobe2), .busy(busy2),
        .done(done2), .conflict_err(err2), .cur_pulse(cur2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input int hi, input int cur, input int lo_len, input int hi_len);
        exp_t e;
        e.hi     = 4'(hi);
        e.med    = 4'((hi + 1) % 16);
        e.lo     = 4'((hi + 15) % 16);
        e.cur    = 8'(cur);
        e.lo_run = lo_len;
        e.hi_run = hi_len;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic sm, input logic [3:0] adr, input logic [7:0] np,
                                 input logic [7:0] sc, input logic [7:0] pc, input bit to2);
        @(negedge clock);
        single_mode = sm;
        single_adr  = adr;
        n_pulses    = np;
        settle_cyc  = sc;
        pulse_cyc   = pc;
        if (to2) start2 = 1'b1;
        else     start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic waitIdle(input bit which, input int bound, input string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (((which ? busy2 : busy) !== 1'b0) && n < bound);
        checkOutput({tag, "_idle"}, 32'(which ? busy2 : busy), 32'd0);
    endtask

    // Readout model: acknowledges ACK_DLY+1 cycles after the enable pulse ends.
    initial begin
        ack_auto = 1'b0;
        forever begin
            @(negedge clock);
            if (ack_en && ack_prev && !mux_en_req) begin
                repeat (ACK_DLY) @(negedge clock);
                ack_auto = 1'b1;
                @(negedge clock);
                ack_auto = 1'b0;
            end
            ack_prev = mux_en_req;
        end
    end

    // Pulse monitor: pops the scoreboard on each rising enable and times the low/high runs.
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_en = 1'b0;
            lo_run  = 0;
            hi_run  = 0;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (pulse_strobe === 1'b1) strobe_cnt++;
            if (mux_en_req === 1'b1) begin
                if (!prev_en) begin
                    checkOutput("strobe_on_rise", 32'(pulse_strobe), 32'd1);
                    checkOutput("sb_nonempty_at_pulse", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        cur_exp = sb.pop_front();
                        checkOutput("high_adr", 32'(high_adr), 32'(cur_exp.hi));
                        checkOutput("med_adr", 32'(med_adr), 32'(cur_exp.med));
                        checkOutput("low_adr", 32'(low_adr), 32'(cur_exp.lo));
                        checkOutput("cur_pulse", 32'(cur_pulse), 32'(cur_exp.cur));
                        checkOutput("en_low_len", 32'(lo_run), 32'(cur_exp.lo_run));
                    end
                    hi_run = 1;
                end else begin
                    hi_run++;
                    checkOutput("strobe_one_cycle", 32'(pulse_strobe), 32'd0);
                    checkOutput("adr_stable_hi", 32'(high_adr), 32'(cur_exp.hi));
                end
            end else begin
                if (prev_en) begin
                    checkOutput("en_high_len", 32'(hi_run), 32'(cur_exp.hi_run));
                    lo_run = 1;
                end else if (busy === 1'b1) begin
                    lo_run++;
                end else begin
                    lo_run = 0;
                end
            end
            prev_en = (mux_en_req === 1'b1);
        end
        if (en2 === 1'b1)   en2_cnt++;
        if (done2 === 1'b1) done2_cnt++;
        if (busy2 === 1'b1) busy2_cyc++;
    end

    initial begin
        int n;
        int d0, s0, e0, b0, dd0;
        reset_n = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0;
        single_mode = 1'b0; single_adr = 4'd0; n_pulses = 8'd1;
        settle_cyc = 8'd4; pulse_cyc = 8'd2; ack_man = 1'b0; ack_en = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_high", 32'(high_adr), 32'd0);
        checkOutput("rst_med", 32'(med_adr), 32'd0);
        checkOutput("rst_low", 32'(low_adr), 32'd0);
        checkOutput("rst_en", 32'(mux_en_req), 32'd0);
        checkOutput("rst_strobe", 32'(pulse_strobe), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(conflict_err), 32'd0);
        checkOutput("rst_cur", 32'(cur_pulse), 32'd0);
        checkOutput("rst_busy2", 32'(busy2), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        $display("[TB] full scan NCH=16");
        for (int i = 0; i < 16; i++) pushExp(i, 0, (i == 0) ? 4 : ACK_DLY + 2 + 4, 2);
        d0 = done_cnt; s0 = strobe_cnt;
        applyStimulus(1'b0, 4'd0, 8'd1, 8'd4, 8'd2, 1'b0);
        checkOutput("scan_busy", 32'(busy), 32'd1);
        waitIdle(1'b0, 1000, "scan");
        repeat (2) @(negedge clock);
        checkOutput("scan_done_cnt", 32'(done_cnt - d0), 32'd1);
        checkOutput("scan_strobes", 32'(strobe_cnt - s0), 32'd16);
        checkOutput("scan_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("scan_err", 32'(conflict_err), 32'd0);

        $display("[TB] single mode channel 5, three pulses");
        pushExp(5, 0, 4, 2);
        pushExp(5, 1, ACK_DLY + 2 + 4, 2);
        pushExp(5, 2, ACK_DLY + 2 + 4, 2);
        d0 = done_cnt; s0 = strobe_cnt;
        applyStimulus(1'b1, 4'd5, 8'd3, 8'd4, 8'd2, 1'b0);
        waitIdle(1'b0, 500, "single");
        repeat (2) @(negedge clock);
        checkOutput("single_done_cnt", 32'(done_cnt - d0), 32'd1);
        checkOutput("single_strobes", 32'(strobe_cnt - s0), 32'd3);
        checkOutput("single_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("single_cur_back0", 32'(cur_pulse), 32'd0);

        $display("[TB] NCH=2 scan always conflicts");
        e0 = en2_cnt; dd0 = done2_cnt; b0 = busy2_cyc;
        applyStimulus(1'b0, 4'd0, 8'd1, 8'd4, 8'd2, 1'b1);
        waitIdle(1'b1, 200, "nch2");
        repeat (2) @(negedge clock);
        checkOutput("nch2_no_enable", 32'(en2_cnt - e0), 32'd0);
        checkOutput("nch2_err", 32'(err2), 32'd1);
        checkOutput("nch2_done_cnt", 32'(done2_cnt - dd0), 32'd1);
        checkOutput("nch2_busy_cycles", 32'(busy2_cyc - b0), 32'd10);

        $display("[TB] new start clears sticky error, then abort");
        dd0 = done2_cnt;
        applyStimulus(1'b0, 4'd0, 8'd1, 8'd4, 8'd2, 1'b1);
        checkOutput("restart_err_clear", 32'(err2), 32'd0);
        checkOutput("restart_busy2", 32'(busy2), 32'd1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checkOutput("abort2_busy", 32'(busy2), 32'd0);
        repeat (8) @(negedge clock);
        checkOutput("abort2_no_done", 32'(done2_cnt - dd0), 32'd0);

        $display("[TB] abort during second pulse cycle");
        pushExp(0, 0, 2, 2);
        d0 = done_cnt;
        applyStimulus(1'b0, 4'd0, 8'd1, 8'd2, 8'd4, 1'b0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (pulse_strobe !== 1'b1 && n < 100);
        checkOutput("abort_strobe_seen", 32'(pulse_strobe), 32'd1);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checkOutput("abort_en_low", 32'(mux_en_req), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        repeat (8) @(negedge clock);
        checkOutput("abort_no_done", 32'(done_cnt - d0), 32'd0);
        checkOutput("abort_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] async reset while waiting for readout");
        ack_en = 1'b0;
        pushExp(0, 0, 1, 1);
        applyStimulus(1'b0, 4'd0, 8'd1, 8'd1, 8'd1, 1'b0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (pulse_strobe !== 1'b1 && n < 100);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (mux_en_req !== 1'b0 && n < 50);
        checkOutput("wait_busy", 32'(busy), 32'd1);
        checkOutput("wait_med", 32'(med_adr), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_med", 32'(med_adr), 32'd0);
        checkOutput("arst_low", 32'(low_adr), 32'd0);
        checkOutput("arst_en", 32'(mux_en_req), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        ack_man = 1'b1;
        @(negedge clock);
        ack_man = 1'b0;
        @(negedge clock);
        checkOutput("ack_in_idle_ignored", 32'(busy), 32'd0);
        ack_en = 1'b1;

        $display("[TB] readout_ack during SETTLE ignored");
        pushExp(2, 0, 4, 2);
        d0 = done_cnt; s0 = strobe_cnt;
        applyStimulus(1'b1, 4'd2, 8'd1, 8'd4, 8'd2, 1'b0);
        ack_man = 1'b1;
        @(negedge clock);
        ack_man = 1'b0;
        waitIdle(1'b0, 200, "settle_ack");
        repeat (2) @(negedge clock);
        checkOutput("settle_ack_strobes", 32'(strobe_cnt - s0), 32'd1);
        checkOutput("settle_ack_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("settle_ack_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] zero config treated as one, start while busy ignored");
        pushExp(7, 0, 1, 1);
        d0 = done_cnt; s0 = strobe_cnt;
        applyStimulus(1'b1, 4'd7, 8'd0, 8'd0, 8'd0, 1'b0);
        single_adr = 4'd9;
        n_pulses   = 8'd3;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitIdle(1'b0, 200, "zero_cfg");
        repeat (10) @(negedge clock);
        checkOutput("zero_cfg_strobes", 32'(strobe_cnt - s0), 32'd1);
        checkOutput("zero_cfg_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("zero_cfg_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("zero_cfg_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
